demod_mode_ctrl: RTL and testbench
==================================

Name: demod_mode_ctrl

Overview:
- Sequences switching of the receiver audio path between the FM and AM demodulator outputs.
- Prevents clicks and transients: ramps audio gain down, flushes and settles the newly selected demodulator, then ramps gain back up.
- Also provides a user mute using the same ramp.
- Sits between the FM/AM demodulators and the audio/PWM output stage; advances only on the shared sample strobe.

Parameters:
DATA_W, 12, audio sample width (signed)
GAIN_STEP, 16, gain increment/decrement per sample; full scale is 256
SETTLE_SAMPLES, 32, samples held muted after a flush before ramping up

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
sample_en  input  1  one-cycle strobe, input sample valid
mode_req  input  1  requested mode: 0=FM, 1=AM
mute_req  input  1  level; 1 requests mute
fm_in  input  DATA_W  signed FM demod output
am_in  input  DATA_W  signed AM demod output
audio_out  output  DATA_W  signed gained audio
audio_valid  output  1  one-cycle pulse, audio_out updated
mode_active  output  1  mode currently routed
demod_flush  output  1  one-cycle pulse, clear demod history/DC state
busy  output  1  high whenever state != RUN

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - state=SETTLE, gain=0, settle counter=SETTLE_SAMPLES.
  - mode_active=mode_req sampled at reset.
  - audio_out=0, audio_valid=0, demod_flush=0, busy=1.
- Gain is unsigned, range 0..256 (9 bits). State changes, gain updates and counter updates happen only in cycles with sample_en=1. Exception: mode_active/demod_flush updates occur on the transition cycle itself.
- Datapath:
  - sel = mode_active ? am_in : fm_in.
  - audio_out = (sel * gain) >>> 8, signed 12x10 multiply, 22-bit product, arithmetic-shift truncation, registered.
  - Gain 256 gives exact passthrough. Gain 0 gives 0.
  - Latency: audio_out/audio_valid update 1 cycle after sample_en, using the gain value before that sample's update.
- States:
  - RUN (gain=256): if mute_req=1 or mode_req!=mode_active -> RAMP_DN.
  - RAMP_DN: gain -= GAIN_STEP, saturating at 0.
    - If mute_req=0 and mode_req==mode_active -> RAMP_UP (abort, keep current gain).
    - Else when the new gain reaches 0: if mute_req -> MUTED; otherwise -> SETTLE, with mode_active<=mode_req, demod_flush pulse, counter<=SETTLE_SAMPLES.
  - SETTLE (gain=0): counter decrements per sample.
    - mute_req -> MUTED.
    - mode_req!=mode_active -> mode_active<=mode_req, counter reloaded, demod_flush pulse again.
    - Counter reaching 0 -> RAMP_UP.
  - RAMP_UP: gain += GAIN_STEP, saturating at 256.
    - If mute_req or mode_req!=mode_active -> RAMP_DN from the current gain.
    - When gain reaches 256 -> RUN.
  - MUTED (gain=0): when mute_req=0 -> SETTLE, with mode_active<=mode_req, demod_flush pulse, counter loaded.
- Simultaneous events: mute has priority over a mode change. The abort check is evaluated before the reach-zero check.
- sample_en held high every cycle is legal. With no sample_en, all state holds and audio_valid=0.
- Reset mid-ramp: immediate return to reset values; no flush pulse is issued by reset.

Optional Feature:
DEMOD_CTRL_DC_BLOCK_EN
- Defined:
  - First-order DC blocker after the gain stage: y = g - dc, then dc += (g - dc) >>> 5, with dc 14-bit signed.
  - The dc accumulator clears on reset and on each demod_flush.
  - audio_out is saturated to DATA_W.
  - Latency becomes 2 cycles from sample_en to audio_valid.
- Undefined: no blocker; latency 1 cycle.

Test Plan:
1. Startup: reset with mode_req=0, fm_in=1000, sample_en every 4 clk.
   - audio_out=0 for 32 samples.
   - Ramp sequence 62, 125, 187, ... reaching 1000 on the 16th ramp sample.
   - busy falls on entry to RUN; mode_active=0.
2. Mode switch: from RUN, set mode_req=1, am_in=-512.
   - 16-sample ramp of fm_in to 0.
   - Exactly one demod_flush pulse; mode_active=1.
   - 32 zero samples, then -32, -64, ... -512.
3. Abort: from RUN, set mode_req=1 for 5 samples, then back to 0.
   - Gain falls to 176, then rises back to 256.
   - No flush; mode_active stays 0.
4. Mute: mute_req=1 at gain 128 during RAMP_UP.
   - Ramps to 0 in 8 samples; enters MUTED with no flush.
   - Release mute -> one flush, 32 settle samples, then ramp up.
5. Extremes: in RUN with fm_in=-2048, then fm_in=2047.
   - audio_out=-2048, then 2047, exactly.
   - With sample_en low for 100 cycles: no audio_valid, state unchanged.
6. Reset mid RAMP_DN at gain 96.
   - Next cycle: audio_out=0, gain=0, state SETTLE, busy=1, no demod_flush.

Source files
------------

// File: rtl/demod_mode_ctrl_if.sv
// Sample-strobed bundle between the FM/AM demodulators, the mode controller and the audio output stage.
// master = sample source / observer side, slave = mode controller side.
interface demod_mode_ctrl_if #(
    parameter int DATA_W = 12
);
    logic                     sample_en;
    logic                     mode_req;
    logic                     mute_req;
    logic signed [DATA_W-1:0] fm_in;
    logic signed [DATA_W-1:0] am_in;
    logic signed [DATA_W-1:0] audio_out;
    logic                     audio_valid;
    logic                     mode_active;
    logic                     demod_flush;
    logic                     busy;

    modport master (
        output sample_en, mode_req, mute_req, fm_in, am_in,
        input  audio_out, audio_valid, mode_active, demod_flush, busy
    );

    modport slave (
        input  sample_en, mode_req, mute_req, fm_in, am_in,
        output audio_out, audio_valid, mode_active, demod_flush, busy
    );
endinterface

// File: rtl/demod_mode_ctrl.sv
// FM/AM audio path switch and mute sequencer with click-free gain ramps; optional DC blocker under DEMOD_CTRL_DC_BLOCK_EN.
// Latency 1 cycle sample_en->audio_valid (2 with the DC blocker); no backpressure, advances only on sample_en.
module demod_mode_ctrl #(
    parameter int DATA_W         = 12,
    parameter int GAIN_STEP      = 16,
    parameter int SETTLE_SAMPLES = 32
) (
    input logic              clk,
    input logic              rst_n,
    demod_mode_ctrl_if.slave bus
);
    localparam int                 CNT_W     = $clog2(SETTLE_SAMPLES + 1);
    localparam logic [8:0]         GAIN_FULL = 9'd256;
    localparam logic [8:0]         STEP      = 9'(GAIN_STEP);
    localparam logic [CNT_W-1:0]   CNT_LOAD  = CNT_W'(SETTLE_SAMPLES);

    typedef enum logic [2:0] {RUN, RAMP_DN, SETTLE, RAMP_UP, MUTED} state_e;

    state_e                   state_q;
    logic [8:0]               gain_q;
    logic [CNT_W-1:0]         cnt_q;
    logic                     mode_active_q;
    logic                     flush_q;
    logic                     busy_q;
    logic signed [DATA_W-1:0] audio_q;
    logic                     valid_q;

    logic [8:0]               gain_dn_d;
    logic [8:0]               gain_up_d;
    logic [CNT_W-1:0]         cnt_dec_d;
    logic                     mode_chg_d;
    logic                     want_dn_d;
    logic signed [DATA_W-1:0] sel_d;
    logic signed [DATA_W+9:0] prod_d;
    logic signed [DATA_W-1:0] gained_d;

    always_comb begin
        gain_dn_d  = (gain_q > STEP) ? gain_q - STEP : '0;
        gain_up_d  = (gain_q >= GAIN_FULL - STEP) ? GAIN_FULL : gain_q + STEP;
        cnt_dec_d  = cnt_q - CNT_W'(1);
        mode_chg_d = bus.mode_req != mode_active_q;
        want_dn_d  = bus.mute_req | mode_chg_d;
        sel_d      = mode_active_q ? bus.am_in : bus.fm_in;
        // gain is unsigned 0..256, so widen with a zero MSB before the signed multiply
        prod_d     = sel_d * $signed({1'b0, gain_q});
        gained_d   = DATA_W'(prod_d >>> 8);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= SETTLE;
            gain_q        <= '0;
            cnt_q         <= CNT_LOAD;
            mode_active_q <= bus.mode_req;
            flush_q       <= 1'b0;
            busy_q        <= 1'b1;
        end else begin
            flush_q <= 1'b0;
            if (bus.sample_en) begin
                unique case (state_q)
                    RUN: begin
                        if (want_dn_d) begin
                            state_q <= RAMP_DN;
                            gain_q  <= gain_dn_d;
                            busy_q  <= 1'b1;
                        end
                    end
                    RAMP_DN: begin
                        // a withdrawn request turns the ramp around before the zero check
                        if (!want_dn_d) begin
                            state_q <= RAMP_UP;
                        end else begin
                            gain_q <= gain_dn_d;
                            if (gain_dn_d == '0) begin
                                if (bus.mute_req) begin
                                    state_q <= MUTED;
                                end else begin
                                    state_q       <= SETTLE;
                                    mode_active_q <= bus.mode_req;
                                    flush_q       <= 1'b1;
                                    cnt_q         <= CNT_LOAD;
                                end
                            end
                        end
                    end
                    SETTLE: begin
                        if (bus.mute_req) begin
                            state_q <= MUTED;
                        end else if (mode_chg_d) begin
                            mode_active_q <= bus.mode_req;
                            flush_q       <= 1'b1;
                            cnt_q         <= CNT_LOAD;
                        end else begin
                            cnt_q <= cnt_dec_d;
                            if (cnt_dec_d == '0) begin
                                state_q <= RAMP_UP;
                                gain_q  <= gain_up_d;
                            end
                        end
                    end
                    RAMP_UP: begin
                        if (want_dn_d) begin
                            state_q <= RAMP_DN;
                            gain_q  <= gain_dn_d;
                        end else begin
                            gain_q <= gain_up_d;
                            if (gain_up_d == GAIN_FULL) begin
                                state_q <= RUN;
                                busy_q  <= 1'b0;
                            end
                        end
                    end
                    MUTED: begin
                        if (!bus.mute_req) begin
                            state_q       <= SETTLE;
                            mode_active_q <= bus.mode_req;
                            flush_q       <= 1'b1;
                            cnt_q         <= CNT_LOAD;
                        end
                    end
                    default: state_q <= SETTLE;
                endcase
            end
        end
    end

`ifdef DEMOD_CTRL_DC_BLOCK_EN
    localparam int                   DC_W  = 14;
    localparam logic signed [DC_W:0] Y_MAX = (DC_W+1)'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [DC_W:0] Y_MIN = -(DC_W+1)'(2 ** (DATA_W - 1));

    logic signed [DATA_W-1:0] g_q;
    logic                     g_vld_q;
    logic signed [DC_W-1:0]   dc_q;
    logic signed [DC_W:0]     diff_d;
    logic signed [DATA_W-1:0] y_sat_d;

    always_comb begin
        diff_d = (DC_W+1)'(g_q) - (DC_W+1)'(dc_q);
        if (diff_d > Y_MAX) begin
            y_sat_d = Y_MAX[DATA_W-1:0];
        end else if (diff_d < Y_MIN) begin
            y_sat_d = Y_MIN[DATA_W-1:0];
        end else begin
            y_sat_d = DATA_W'(diff_d);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            g_q     <= '0;
            g_vld_q <= 1'b0;
            dc_q    <= '0;
            audio_q <= '0;
            valid_q <= 1'b0;
        end else begin
            g_vld_q <= bus.sample_en;
            valid_q <= g_vld_q;
            if (bus.sample_en) begin
                g_q <= gained_d;
            end
            // the new demodulator starts with a fresh DC estimate
            if (flush_q) begin
                dc_q <= '0;
            end else if (g_vld_q) begin
                dc_q <= dc_q + DC_W'(diff_d >>> 5);
            end
            if (g_vld_q) begin
                audio_q <= y_sat_d;
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            audio_q <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= bus.sample_en;
            if (bus.sample_en) begin
                audio_q <= gained_d;
            end
        end
    end
`endif

    assign bus.audio_out   = audio_q;
    assign bus.audio_valid = valid_q;
    assign bus.mode_active = mode_active_q;
    assign bus.demod_flush = flush_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_demod_mode_ctrl.sv
// Bench for demod_mode_ctrl: directed ramp/switch/mute/reset sequences, a RUN-state vector table,
// and a randomized run against a gain/settle reference model.
module tb_demod_mode_ctrl;
    localparam int DATA_W = 12;
    localparam int STEP   = 16;
    localparam int FULL   = 256;
    localparam int SETTLE = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    demod_mode_ctrl_if #(.DATA_W(DATA_W)) bus ();

    demod_mode_ctrl #(
        .DATA_W(DATA_W), .GAIN_STEP(STEP), .SETTLE_SAMPLES(SETTLE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int flush_cnt = 0;

    always @(negedge clk) if (bus.demod_flush === 1'b1) flush_cnt++;

    function automatic void chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    int s_out;
    bit s_vld;

    // one sample strobe followed by three idle clocks
    task automatic do_sample(input int fm, input int am, input bit mode, input bit mute);
        bus.fm_in     = DATA_W'(fm);
        bus.am_in     = DATA_W'(am);
        bus.mode_req  = mode;
        bus.mute_req  = mute;
        bus.sample_en = 1'b1;
        @(posedge clk); #1;
        s_out = int'(bus.audio_out);
        s_vld = bus.audio_valid;
        bus.sample_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input bit mode);
        bus.sample_en = 1'b0;
        bus.mute_req  = 1'b0;
        bus.mode_req  = mode;
        bus.fm_in     = '0;
        bus.am_in     = '0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // reference model: gain plus settle countdown, mute latch and ramp direction
    int m_gain, m_cnt, m_dir;
    bit m_muted, m_mode;

    task automatic model_step(input bit mreq, input bit mute, output bit fl);
        bit want;
        fl = 1'b0;
        want = !mute && (mreq == m_mode);
        if (m_muted) begin
            if (!mute) begin
                m_muted = 1'b0; m_mode = mreq; m_cnt = SETTLE; fl = 1'b1;
            end
        end else if (m_cnt > 0) begin
            if (mute) begin
                m_muted = 1'b1; m_cnt = 0;
            end else if (mreq != m_mode) begin
                m_mode = mreq; m_cnt = SETTLE; fl = 1'b1;
            end else begin
                m_cnt--;
                if (m_cnt == 0) begin m_gain = STEP; m_dir = 1; end
            end
        end else if (m_dir < 0) begin
            if (want) m_dir = 1;
            else begin
                m_gain = (m_gain > STEP) ? m_gain - STEP : 0;
                if (m_gain == 0) begin
                    m_dir = 0;
                    if (mute) m_muted = 1'b1;
                    else begin m_mode = mreq; m_cnt = SETTLE; fl = 1'b1; end
                end
            end
        end else if (!want) begin
            m_dir = -1;
            m_gain = (m_gain > STEP) ? m_gain - STEP : 0;
        end else if (m_dir > 0) begin
            m_gain = (m_gain + STEP >= FULL) ? FULL : m_gain + STEP;
            if (m_gain == FULL) m_dir = 0;
        end
    endtask

    typedef struct { int fm; int am; int exp; } vec_t;
    vec_t vt[6];
    int   exp3[12];

    initial begin
        int f0;
        bit en, mreq, mute, burst, e_vld, e_flush;
        int fm, am, sel, e_out;

        vt[0] = '{fm: -2048, am: 5,     exp: -2048};
        vt[1] = '{fm: 2047,  am: -7,    exp: 2047};
        vt[2] = '{fm: 0,     am: 100,   exp: 0};
        vt[3] = '{fm: -1,    am: 2047,  exp: -1};
        vt[4] = '{fm: 1,     am: -2048, exp: 1};
        vt[5] = '{fm: 1234,  am: 0,     exp: 1234};
        exp3  = '{256, 240, 224, 208, 192, 176, 176, 192, 208, 224, 240, 256};

        // reset values; mode_active follows mode_req during reset
        do_reset(1'b1);
        chk("rst_mode_am", int'(bus.mode_active), 1);
        do_reset(1'b0);
        chk("rst_mode_fm", int'(bus.mode_active), 0);
        chk("rst_out", int'(bus.audio_out), 0);
        chk("rst_valid", int'(bus.audio_valid), 0);
        chk("rst_flush", int'(bus.demod_flush), 0);
        chk("rst_busy", int'(bus.busy), 1);

        // startup: 32 muted settle samples then a 16-sample ramp
        f0 = flush_cnt;
        for (int k = 1; k <= SETTLE; k++) begin
            do_sample(1000, 0, 1'b0, 1'b0);
            chk("startup_zero", s_out, 0);
        end
        chk("startup_valid", int'(s_vld), 1);
        for (int k = 1; k <= 16; k++) begin
            do_sample(1000, 0, 1'b0, 1'b0);
            chk("startup_ramp", s_out, (1000 * STEP * k) >>> 8);
            if (k == 14) chk("startup_busy_hi", int'(bus.busy), 1);
            if (k == 15) chk("startup_busy_lo", int'(bus.busy), 0);
        end
        chk("startup_mode", int'(bus.mode_active), 0);
        chk("startup_noflush", flush_cnt - f0, 0);

        // RUN passthrough table, including the extremes
        for (int i = 0; i < 6; i++) begin
            do_sample(vt[i].fm, vt[i].am, 1'b0, 1'b0);
            chk("run_vec", s_out, vt[i].exp);
            chk("run_vec_valid", int'(s_vld), 1);
        end
        begin
            int vc = 0;
            repeat (100) begin
                @(posedge clk); #1;
                if (bus.audio_valid) vc++;
            end
            chk("idle_valid", vc, 0);
            chk("idle_hold", int'(bus.audio_out), vt[5].exp);
            chk("idle_busy", int'(bus.busy), 0);
        end
        do_sample(300, 0, 1'b0, 1'b0);
        chk("idle_resume", s_out, 300);

        // abort: five samples of mode request then withdrawn (fm=256 so audio equals gain)
        f0 = flush_cnt;
        for (int i = 0; i < 12; i++) begin
            do_sample(256, 0, (i < 5), 1'b0);
            chk("abort_gain", s_out, exp3[i]);
        end
        chk("abort_noflush", flush_cnt - f0, 0);
        chk("abort_mode", int'(bus.mode_active), 0);
        chk("abort_busy", int'(bus.busy), 0);

        // mute from RUN, release, then mute again mid ramp-up at gain 128
        f0 = flush_cnt;
        for (int i = 0; i < 16; i++) begin
            do_sample(256, 0, 1'b0, 1'b1);
            chk("mute_dn", s_out, FULL - STEP * i);
        end
        do_sample(256, 0, 1'b0, 1'b1);
        chk("muted_out", s_out, 0);
        chk("muted_busy", int'(bus.busy), 1);
        chk("mute_noflush", flush_cnt - f0, 0);
        f0 = flush_cnt;
        do_sample(256, 0, 1'b0, 1'b0);
        chk("unmute_out", s_out, 0);
        chk("unmute_flush", flush_cnt - f0, 1);
        for (int k = 1; k <= SETTLE; k++) begin
            do_sample(256, 0, 1'b0, 1'b0);
            chk("unmute_settle", s_out, 0);
        end
        for (int k = 1; k <= 7; k++) begin
            do_sample(256, 0, 1'b0, 1'b0);
            chk("unmute_ramp", s_out, STEP * k);
        end
        f0 = flush_cnt;
        for (int i = 0; i < 8; i++) begin
            do_sample(256, 0, 1'b0, 1'b1);
            chk("remute_dn", s_out, 128 - STEP * i);
        end
        do_sample(256, 0, 1'b0, 1'b1);
        chk("remuted_out", s_out, 0);
        chk("remute_noflush", flush_cnt - f0, 0);
        f0 = flush_cnt;
        do_sample(256, 0, 1'b0, 1'b0);
        for (int k = 1; k <= SETTLE; k++) begin
            do_sample(256, 0, 1'b0, 1'b0);
            chk("release_settle", s_out, 0);
        end
        for (int k = 1; k <= 16; k++) begin
            do_sample(256, 0, 1'b0, 1'b0);
            chk("release_ramp", s_out, STEP * k);
        end
        chk("release_flush", flush_cnt - f0, 1);
        chk("release_busy", int'(bus.busy), 0);

        // FM -> AM switch
        f0 = flush_cnt;
        for (int k = 0; k < 16; k++) begin
            do_sample(1000, -512, 1'b1, 1'b0);
            chk("switch_dn", s_out, (1000 * (FULL - STEP * k)) >>> 8);
        end
        chk("switch_mode", int'(bus.mode_active), 1);
        for (int k = 1; k <= SETTLE; k++) begin
            do_sample(1000, -512, 1'b1, 1'b0);
            chk("switch_settle", s_out, 0);
        end
        for (int k = 1; k <= 16; k++) begin
            do_sample(1000, -512, 1'b1, 1'b0);
            chk("switch_up", s_out, -2 * STEP * k);
        end
        chk("switch_flush", flush_cnt - f0, 1);
        chk("switch_busy", int'(bus.busy), 0);

        // reset in the middle of a ramp-down at gain 96
        for (int i = 0; i < 10; i++) begin
            do_sample(0, 256, 1'b1, 1'b1);
            chk("pre_rst_dn", s_out, FULL - STEP * i);
        end
        f0 = flush_cnt;
        do_reset(1'b1);
        chk("midrst_out", int'(bus.audio_out), 0);
        chk("midrst_valid", int'(bus.audio_valid), 0);
        chk("midrst_busy", int'(bus.busy), 1);
        chk("midrst_flush", int'(bus.demod_flush), 0);
        for (int k = 1; k <= SETTLE; k++) begin
            do_sample(0, 256, 1'b1, 1'b0);
            chk("midrst_settle", s_out, 0);
        end
        do_sample(0, 256, 1'b1, 1'b0);
        chk("midrst_ramp", s_out, STEP);
        chk("midrst_noflush", flush_cnt - f0, 0);

        // randomized run against the reference model
        mreq = 1'($urandom_range(0, 1));
        mute = 1'b0;
        burst = 1'b0;
        do_reset(mreq);
        m_gain = 0; m_cnt = SETTLE; m_dir = 0; m_muted = 1'b0; m_mode = mreq;
        e_out = 0;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            if (cyc % 600 == 0) burst = ~burst;
            en = burst ? 1'b1 : ($urandom_range(0, 3) == 0);
            if (en && $urandom_range(0, 39) == 0) mreq = ~mreq;
            if (en && $urandom_range(0, 69) == 0) mute = ~mute;
            fm = int'($urandom_range(0, 4095)) - 2048;
            am = int'($urandom_range(0, 4095)) - 2048;
            bus.sample_en = en;
            bus.mode_req  = mreq;
            bus.mute_req  = mute;
            bus.fm_in     = DATA_W'(fm);
            bus.am_in     = DATA_W'(am);
            e_flush = 1'b0;
            if (en) begin
                sel   = m_mode ? am : fm;
                e_out = (sel * m_gain) >>> 8;
                model_step(mreq, mute, e_flush);
            end
            e_vld = en;
            @(posedge clk); #1;
            chk("rnd_valid", int'(bus.audio_valid), int'(e_vld));
            chk("rnd_out", int'(bus.audio_out), e_out);
            chk("rnd_flush", int'(bus.demod_flush), int'(e_flush));
            chk("rnd_mode", int'(bus.mode_active), int'(m_mode));
            chk("rnd_busy", int'(bus.busy),
                int'(!(!m_muted && m_cnt == 0 && m_dir == 0 && m_gain == FULL)));
        end
        bus.sample_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
